// File: rtl/flag_register.sv
// flag_register: writer side of the condition-flag interface.
//
// Holds the architectural {Z,V,N} flags at the EX/MEM boundary. Flags are computed
// from the EX-stage ALU result and committed one cycle later under a per-opcode
// write mask. A branch-facing view and a decode hazard keep a conditional branch
// in ID from using stale flags.
//
// Optional feature (macro FLAG_FWD_EN):
//   defined   - branch_flags forwards the merged next value from EX; flag_hazard = 0.
//   undefined - branch_flags = flags; flag_hazard stalls ID for one cycle.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ex_valid        EX stage holds a valid instruction
//   ex_opcode       EX-stage opcode
//   alu_result      EX-stage ALU result
//   alu_ovfl        ALU signed-overflow indication
//   stall, flush    either one blocks the flag update
//   id_cond_branch  ID holds a conditional branch
//   clr_sticky      clear the sticky overflow bit
//   flags           registered architectural {Z,V,N}
//   branch_flags    flags the branch unit must use this cycle
//   flag_hazard     stall ID one cycle
//   v_sticky        sticky overflow
//   upd_count       count of committed flag updates (wraps)
module flag_register #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [OPW-1:0]  ex_opcode,
  input  logic [DW-1:0]   alu_result,
  input  logic            alu_ovfl,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_cond_branch,
  input  logic            clr_sticky,
  output logic [2:0]      flags,
  output logic [2:0]      branch_flags,
  output logic            flag_hazard,
  output logic            v_sticky,
  output logic [CNTW-1:0] upd_count
);

  logic [2:0]      flags_q, flags_d;
  logic            sticky_q, sticky_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      mask;
  logic [2:0]      flags_nxt;
  logic            upd;
  logic            writes_flags;

  // Write mask {Z,V,N}; any opcode at or above 4'b1000 writes nothing.
  always_comb begin
    mask = 3'b000;
    case (ex_opcode[2:0])
      3'd0, 3'd1:             mask = 3'b111;
      3'd2, 3'd4, 3'd5, 3'd6: mask = 3'b100;
      default:                mask = 3'b000;
    endcase
    if ((ex_opcode >> 3) != '0) mask = 3'b000;
  end

  // Masked bits take the new value, the rest keep the committed one.
  always_comb begin
    flags_nxt = (mask & {(alu_result == '0), alu_ovfl, alu_result[DW-1]}) | (~mask & flags_q);
  end

  assign writes_flags = ex_valid & ~flush & (mask != 3'b000);
  assign upd          = writes_flags & ~stall;

  always_comb begin
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (upd) begin
      flags_d = flags_nxt;
      cnt_d   = cnt_q + CNTW'(1);
    end
    // Set has priority over clear.
    if (upd && mask[1] && alu_ovfl) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 3'b000;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign flags     = flags_q;
  assign v_sticky  = sticky_q;
  assign upd_count = cnt_q;

`ifdef FLAG_FWD_EN
  logic unused_id_cond_branch;
  assign unused_id_cond_branch = id_cond_branch;

  // Forwarding ignores stall: the branch sees what EX will eventually commit.
  assign branch_flags = !rst_n       ? 3'b000    :
                        writes_flags ? flags_nxt : flags_q;
  assign flag_hazard  = 1'b0;
`else
  assign branch_flags = rst_n ? flags_q : 3'b000;
  assign flag_hazard  = rst_n & id_cond_branch & writes_flags;
`endif

endmodule

// File: tb/tb_flag_register.sv
module tb_flag_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        id_cond_branch;
  logic        clr_sticky;
  logic [2:0]  flags;
  logic [2:0]  branch_flags;
  logic        flag_hazard;
  logic        v_sticky;
  logic [7:0]  upd_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: individual flags, sticky bit, counter as an integer.
  bit m_z, m_v, m_n, m_s;
  int m_cnt;

  flag_register #(.OPW(4), .DW(16), .CNTW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .alu_result     (alu_result),
    .alu_ovfl       (alu_ovfl),
    .stall          (stall),
    .flush          (flush),
    .id_cond_branch (id_cond_branch),
    .clr_sticky     (clr_sticky),
    .flags          (flags),
    .branch_flags   (branch_flags),
    .flag_hazard    (flag_hazard),
    .v_sticky       (v_sticky),
    .upd_count      (upd_count)
  );

  always #5 clk = ~clk;

  // Which flags an opcode writes, as {Z,V,N}.
  function automatic logic [2:0] wmask(input int op);
    if (op == 0 || op == 1) return 3'b111;
    if (op == 2 || op == 4 || op == 5 || op == 6) return 3'b100;
    return 3'b000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int op, input logic [15:0] res, input bit ov,
                       input bit st, input bit fl, input bit idc, input bit clr);
    ex_valid = v; ex_opcode = 4'(op); alu_result = res; alu_ovfl = ov;
    stall = st; flush = fl; id_cond_branch = idc; clr_sticky = clr;
  endtask

  // One clock: check combinational view, take the edge, update model, check registers.
  task automatic cycle(input string tag);
    logic [2:0] wm;
    bit         writes, upd;
    logic [2:0] exp_bf;
    bit         exp_hz;
    wm     = wmask(int'(ex_opcode));
    writes = ex_valid && !flush && wm != 3'b000;
    upd    = writes && !stall;
    exp_bf = {m_z, m_v, m_n};
    exp_hz = id_cond_branch && writes;
`ifdef FLAG_FWD_EN
    if (writes) begin
      if (wm[2]) exp_bf[2] = (alu_result == 16'h0);
      if (wm[1]) exp_bf[1] = alu_ovfl;
      if (wm[0]) exp_bf[0] = alu_result[15];
    end
    exp_hz = 1'b0;
`endif
    #2;
    check({tag, "_bflags"}, 32'(branch_flags), 32'(exp_bf));
    check({tag, "_hazard"}, 32'(flag_hazard), 32'(exp_hz));
    @(posedge clk);
    if (upd) begin
      if (wm[2]) m_z = (alu_result == 16'h0);
      if (wm[1]) m_v = alu_ovfl;
      if (wm[0]) m_n = alu_result[15];
      m_cnt = (m_cnt + 1) % 256;
    end
    if (upd && wm[1] && alu_ovfl) m_s = 1'b1;
    else if (clr_sticky) m_s = 1'b0;
    #1;
    check({tag, "_flags"}, 32'(flags), 32'({m_z, m_v, m_n}));
    check({tag, "_sticky"}, 32'(v_sticky), 32'(m_s));
    check({tag, "_count"}, 32'(upd_count), 32'(m_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 16'h0000, 1, 0, 0, 1, 0);
    m_z = 0; m_v = 0; m_n = 0; m_s = 0; m_cnt = 0;
    #3;
    check("por_flags", 32'(flags), 32'd0);
    check("por_bflags", 32'(branch_flags), 32'd0);
    check("por_hazard", 32'(flag_hazard), 32'd0);
    #4 rst_n = 1'b1;
    drive(0, 0, 16'h0000, 0, 0, 0, 0, 0);
    cycle("idle");

    // ADD 0x8000 with overflow -> 011, sticky, count 1
    drive(1, 0, 16'h8000, 1, 0, 0, 0, 0);
    cycle("add");
    check("add_flags_k", 32'(flags), 32'h3);
    check("add_count_k", 32'(upd_count), 32'h1);

    // XOR result 0 only writes Z -> 111
    drive(1, 2, 16'h0000, 1, 0, 0, 0, 0);
    cycle("xor");
    check("xor_flags_k", 32'(flags), 32'h7);

    // Mid-run reset during a stall, asynchronous to the clock
    drive(1, 1, 16'h0000, 0, 1, 0, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    m_z = 0; m_v = 0; m_n = 0; m_s = 0; m_cnt = 0;
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_sticky", 32'(v_sticky), 32'd0);
    check("rst_count", 32'(upd_count), 32'd0);
    check("rst_bflags", 32'(branch_flags), 32'd0);
    check("rst_hazard", 32'(flag_hazard), 32'd0);
    #2 rst_n = 1'b1;
    drive(0, 0, 16'h0000, 0, 0, 0, 0, 0);
    cycle("post_rst");

    // Back to 011, then PADDSB must not write
    drive(1, 0, 16'h8000, 1, 0, 0, 0, 0);
    cycle("add2");
    drive(1, 7, 16'h0000, 0, 0, 0, 0, 0);
    cycle("paddsb");
    check("paddsb_flags_k", 32'(flags), 32'h3);

    // SUB 0 under stall, then flush, then free with a branch in ID
    drive(1, 1, 16'h0000, 0, 1, 0, 1, 0);
    cycle("sub_stall");
    drive(1, 1, 16'h0000, 0, 0, 1, 1, 0);
    cycle("sub_flush");
    drive(1, 1, 16'h0000, 0, 1, 1, 1, 0);
    cycle("sub_both");
    drive(1, 1, 16'h0000, 0, 0, 0, 1, 0);
    cycle("sub_go");
    check("sub_flags_k", 32'(flags), 32'h4);

    // clear sticky alone, then set and clear together (set wins)
    drive(0, 0, 16'h0000, 0, 0, 0, 0, 1);
    cycle("clr");
    drive(1, 0, 16'h0001, 1, 0, 0, 0, 1);
    cycle("set_clr");

    // Counter wrap
    while (m_cnt != 255) begin
      drive(1, 0, 16'($urandom), $urandom_range(0, 1), 0, 0, 0, 0);
      cycle("fill");
    end
    drive(1, 0, 16'h1234, 0, 0, 0, 0, 0);
    cycle("wrap");
    check("wrap_count_k", 32'(upd_count), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15),
            ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1), $urandom_range(0, 5) == 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
